fnd_scan_controller: RTL and testbench
======================================

# fnd_scan_controller

Time-multiplexed driver for the 4-digit common-anode FND on the MicroBlaze FND IP. It accepts a binary value from the AXI register side and converts it to four BCD digits with a sequential double-dabble engine. It then scans the digits at a programmable rate and drives active-low digit-select and segment lines, using the same font encoding as the existing BCD-to-FND decoding. It sits between the IP's register block and the board pins.

## Interface
- SCAN_DIV, 100_000: clocks per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
- i_clk  in  1  system clock; all state on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_value  in  14  binary value to display; values above 9999 are clamped to 9999.
- i_load  in  1  single-cycle strobe; starts conversion of i_value.
- i_dp  in  4  decimal point per digit, 1 = lit; bit 0 = ones digit. Sampled live.
- i_blank_lz  in  1  1 = blank leading zeros on digits 3..1. Sampled live.
- i_en  in  1  1 = scanning enabled; 0 = all digits off.
- o_busy  out  1  high while conversion is in progress.
- o_fndCom  out  4  digit select, active-low; bit 0 = ones digit.
- o_fndFont  out  8  segments {dp,g..a}, active-low.

## Operation
- Fonts: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Blank=FF. When i_dp of the active digit is set, bit 7 is cleared.
- Converter FSM:
  - IDLE: when i_load=1, capture min(i_value,9999) into the shift register, clear the BCD accumulator, go to SHIFT.
  - SHIFT: runs 14 iterations, one per clock. Each iteration first adds 3 to every BCD nibble ≥5, then shifts left by 1. After the 14th iteration, go to DONE.
  - DONE: copy the 4 BCD nibbles into the display register, go to IDLE.
- i_load while not IDLE is ignored; no queueing. Software must poll o_busy.
- The display register holds its value until the next DONE. Scanning always reads the display register, never the in-progress accumulator.
- Prescaler: counts 0..SCAN_DIV-1 and emits a one-cycle tick on the terminal count. The digit index (2-bit) increments on each tick and wraps 3→0.
- Leading-zero blanking: digit k (k=3..1) is blanked when i_blank_lz=1 and all display digits k..3 are 0. Digit 0 is never blanked.
- When blanked, the font is FF, but a set i_dp still clears bit 7.
- When i_en=0: o_fndCom=F and o_fndFont=FF. The prescaler and index keep running.

## Timing
- Reset values:
  - o_fndCom=F, o_fndFont=FF, o_busy=0.
  - Display register 0000, digit index 0, prescaler 0, FSM IDLE.
- Conversion latency:
  - i_load is sampled at edge E0. o_busy is 1 from E0 until E15.
  - The display register updates at E15, and o_busy falls at E15.
  - Total is 15 cycles from load to new display data.
- o_fndCom and o_fndFont are registered. They reflect the new digit index, display data, i_dp, i_blank_lz and i_en one cycle after the tick edge or input change.
- Digit-select overlap is not allowed: exactly one o_fndCom bit is low whenever i_en=1 after the first post-reset clock.
- Simultaneous DONE and tick: the new display data is used starting from the next registered output update.
- Reset mid-conversion: returns to IDLE immediately; the display register is cleared to 0000.

## Test plan
- Reset with SCAN_DIV=4, i_en=1, i_blank_lz=0 → after reset release, o_fndCom cycles E,D,B,7 every 4 clocks; o_fndFont=C0 on all digits.
- i_load with i_value=1234 → o_busy high exactly 15 cycles, then per digit o_fndCom=E:99, D:B0, B:A4, 7:F9.
- i_value=12000 with i_load → display 9999; every digit shows 90.
- i_value=5, i_blank_lz=1, i_dp=4'b0100 → ones digit=92, tens=FF, hundreds=7F, thousands=FF.
- Second i_load during a conversion → ignored; o_busy still falls 15 cycles after the first load with the first value. Assert i_reset_n=0 mid-conversion → o_busy=0, outputs F/FF immediately, display 0000.
- i_en=0 for 20 cycles → o_fndCom=F, o_fndFont=FF. On re-enable, scanning resumes at the index the free-running counter has reached.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: converts a clamped 14-bit binary value to four BCD
// digits with a sequential double-dabble engine, then time-multiplexes the
// digits onto a common-anode 4-digit FND using active-low select and segment lines.
module fnd_scan_controller #(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic [3:0]  i_dp,
  input  logic        i_blank_lz,
  input  logic        i_en,
  output logic        o_busy,
  output logic [3:0]  o_fndCom,
  output logic [7:0]  o_fndFont
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [13:0]      r_bin;
  logic [15:0]      r_bcd;
  logic [3:0]       r_iter;
  logic [15:0]      r_disp;
  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [3:0]       r_com;
  logic [7:0]       r_font;

  logic [13:0]      w_clamped;
  logic [15:0]      w_bcd_adj;
  logic             w_tick;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [3:0]       w_zero;
  logic [3:0]       w_com;
  logic [7:0]       w_font;

  assign w_clamped = (i_value > 14'd9999) ? 14'd9999 : i_value;
  assign w_tick    = (r_presc == CNT_LAST);
  assign o_busy    = (r_state != S_IDLE);
  assign o_fndCom  = r_com;
  assign o_fndFont = r_font;

  // Active-low seven-segment font {dp,g..a}; dp is off in every glyph.
  function automatic logic [7:0] font_of(input logic [3:0] d);
    case (d)
      4'd0:    font_of = 8'hC0;
      4'd1:    font_of = 8'hF9;
      4'd2:    font_of = 8'hA4;
      4'd3:    font_of = 8'hB0;
      4'd4:    font_of = 8'h99;
      4'd5:    font_of = 8'h92;
      4'd6:    font_of = 8'h82;
      4'd7:    font_of = 8'hF8;
      4'd8:    font_of = 8'h80;
      4'd9:    font_of = 8'h90;
      default: font_of = 8'hFF;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3
                                                       : r_bcd[4*k +: 4];
    end
  end

  // Converter next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_load) w_state_next = S_SHIFT;
      S_SHIFT: if (r_iter == 4'd13) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Converter state register and shift/accumulate datapath.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_iter  <= '0;
      r_disp  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_bin  <= w_clamped;
            r_bcd  <= '0;
            r_iter <= '0;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
          r_iter         <= r_iter + 4'd1;
        end
        S_DONE:  r_disp <= r_bcd;
        default: ;
      endcase
    end
  end

  // Free-running prescaler and digit index; both keep running while disabled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digit selection, leading-zero blanking and decimal point for the active slot.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_zero[k] = (r_disp[4*k +: 4] == 4'd0);
    end
    w_digit = r_disp[4*r_idx +: 4];
    w_blank = 1'b0;
    case (r_idx)
      2'd3:    w_blank = i_blank_lz & w_zero[3];
      2'd2:    w_blank = i_blank_lz & w_zero[3] & w_zero[2];
      2'd1:    w_blank = i_blank_lz & w_zero[3] & w_zero[2] & w_zero[1];
      default: w_blank = 1'b0;
    endcase
    w_font = w_blank ? 8'hFF : font_of(w_digit);
    if (i_dp[r_idx]) w_font[7] = 1'b0;
    w_com = ~(4'b0001 << r_idx);
    if (!i_en) begin
      w_com  = 4'hF;
      w_font = 8'hFF;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_com  <= 4'hF;
      r_font <= 8'hFF;
    end else begin
      r_com  <= w_com;
      r_font <= w_font;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with a short scan period.
module tb_fnd_scan_controller;

  localparam int unsigned SCAN_DIV = 4;

  logic        i_clk;
  logic        i_reset_n;
  logic [13:0] i_value;
  logic        i_load;
  logic [3:0]  i_dp;
  logic        i_blank_lz;
  logic        i_en;
  logic        o_busy;
  logic [3:0]  o_fndCom;
  logic [7:0]  o_fndFont;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // rising edges since the last reset release

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_value    (i_value),
    .i_load     (i_load),
    .i_dp       (i_dp),
    .i_blank_lz (i_blank_lz),
    .i_en       (i_en),
    .o_busy     (o_busy),
    .o_fndCom   (o_fndCom),
    .o_fndFont  (o_fndFont)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected digit select after the most recent edge: the registered output
  // shows the index held before that edge, which advances every SCAN_DIV edges.
  function automatic logic [3:0] model_com(input int n);
    int idx;
    idx = ((n - 1) / SCAN_DIV) % 4;
    return ~(4'b0001 << idx);
  endfunction

  // Wait (bounded) for a digit slot, then check its select and font.
  task automatic wait_digit(input string tag, input logic [3:0] com, input logic [7:0] font);
    for (int i = 0; i < 20; i++) begin
      if (o_fndCom === com) break;
      @(negedge i_clk);
    end
    check({tag, "_com"}, 32'(o_fndCom), 32'(com));
    check({tag, "_font"}, 32'(o_fndFont), 32'(font));
  endtask

  // Pulse i_load for one edge, then wait (bounded) for o_busy to fall.
  task automatic do_load(input logic [13:0] v);
    i_value = v;
    i_load  = 1'b1;
    @(negedge i_clk);
    i_load  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!o_busy) break;
      @(negedge i_clk);
    end
    check("busy_fall", 32'(o_busy), 32'd0);
    @(negedge i_clk);
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_value    = '0;
    i_load     = 1'b0;
    i_dp       = 4'b0000;
    i_blank_lz = 1'b0;
    i_en       = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_com",  32'(o_fndCom),  32'hF);
    check("rst_font", 32'(o_fndFont), 32'hFF);
    check("rst_busy", 32'(o_busy),    32'd0);

    // Scan order and timing after reset: E,D,B,7 for 4 clocks each, all "0".
    i_reset_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge i_clk);
      check($sformatf("scan_com_%0d", n), 32'(o_fndCom), 32'(model_com(n)));
      check($sformatf("scan_font_%0d", n), 32'(o_fndFont), 32'hC0);
    end

    // 1234: busy high for exactly 15 sampled cycles.
    i_value = 14'd1234;
    i_load  = 1'b1;
    @(negedge i_clk);
    i_load  = 1'b0;
    check("busy_e0", 32'(o_busy), 32'd1);
    for (int i = 1; i <= 14; i++) begin
      @(negedge i_clk);
      check($sformatf("busy_e%0d", i), 32'(o_busy), 32'd1);
    end
    @(negedge i_clk);
    check("busy_e15", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    wait_digit("v1234_d0", 4'hE, 8'h99);
    wait_digit("v1234_d1", 4'hD, 8'hB0);
    wait_digit("v1234_d2", 4'hB, 8'hA4);
    wait_digit("v1234_d3", 4'h7, 8'hF9);

    // Clamp above 9999.
    do_load(14'd12000);
    wait_digit("clamp_d0", 4'hE, 8'h90);
    wait_digit("clamp_d1", 4'hD, 8'h90);
    wait_digit("clamp_d2", 4'hB, 8'h90);
    wait_digit("clamp_d3", 4'h7, 8'h90);

    // Leading-zero blanking with a decimal point on a blanked digit.
    i_blank_lz = 1'b1;
    i_dp       = 4'b0100;
    do_load(14'd5);
    wait_digit("lz_d0", 4'hE, 8'h92);
    wait_digit("lz_d1", 4'hD, 8'hFF);
    wait_digit("lz_d2", 4'hB, 8'h7F);
    wait_digit("lz_d3", 4'h7, 8'hFF);
    i_blank_lz = 1'b0;
    i_dp       = 4'b0000;

    // Second load during conversion is ignored.
    i_value = 14'd4321;
    i_load  = 1'b1;
    @(negedge i_clk);
    i_load  = 1'b0;
    repeat (4) @(negedge i_clk);
    i_value = 14'd8888;
    i_load  = 1'b1;
    @(negedge i_clk);
    i_load  = 1'b0;
    repeat (9) @(negedge i_clk);
    check("ign_busy_e14", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    check("ign_busy_e15", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    wait_digit("ign_d0", 4'hE, 8'hF9);
    wait_digit("ign_d1", 4'hD, 8'hA4);
    wait_digit("ign_d2", 4'hB, 8'hB0);
    wait_digit("ign_d3", 4'h7, 8'h99);

    // Reset in the middle of a conversion.
    i_value = 14'd7777;
    i_load  = 1'b1;
    @(negedge i_clk);
    i_load  = 1'b0;
    repeat (5) @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(o_busy),    32'd0);
    check("mid_rst_com",  32'(o_fndCom),  32'hF);
    check("mid_rst_font", 32'(o_fndFont), 32'hFF);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    wait_digit("post_rst_d0", 4'hE, 8'hC0);
    wait_digit("post_rst_d1", 4'hD, 8'hC0);
    wait_digit("post_rst_d2", 4'hB, 8'hC0);
    wait_digit("post_rst_d3", 4'h7, 8'hC0);

    // Disable for 20 cycles, then resume at the free-running index.
    i_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      check($sformatf("dis_com_%0d", i),  32'(o_fndCom),  32'hF);
      check($sformatf("dis_font_%0d", i), 32'(o_fndFont), 32'hFF);
    end
    i_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      check($sformatf("resume_com_%0d", i), 32'(o_fndCom), 32'(model_com(cyc)));
      check($sformatf("resume_font_%0d", i), 32'(o_fndFont), 32'hC0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
